// File: rtl/abh_ext.sv
// rtl/abh_ext.sv - address-bus-high unit with deferred carry, hold and page-cross counter
module abh_ext #(
  parameter int                WIDTH       = 8,
  parameter int                DEFER_CARRY = 0,
  parameter logic [WIDTH-1:0]  ZP_PAGE     = '0,
  parameter logic [WIDTH-1:0]  STACK_PAGE  = WIDTH'(1),
  parameter logic [WIDTH-1:0]  VEC_PAGE    = '1,
  parameter logic [WIDTH-1:0]  RESET_PAGE  = '1,
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CI,
  input  logic [WIDTH-1:0]  DB,
  input  logic [3:0]        op,
  input  logic              ld_pc,
  input  logic              inc_pc,
  input  logic              hold,
  output logic [WIDTH-1:0]  ADH,
  output logic [WIDTH-1:0]  ABH,
  output logic [WIDTH-1:0]  PCH,
  output logic              stall,
  output logic              page_cross,
  output logic [CNT_W-1:0]  pc_count
);

  typedef enum logic {S_NORMAL, S_FIXUP} state_t;

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] abh_q;
  logic [WIDTH-1:0] pch_q;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] page_adh;
  logic [WIDTH-1:0] adh_c;
  logic             computed;
  logic             stall_c;
  logic             cross_c;
  logic             pcross_q;
  logic [CNT_W-1:0] cnt_q;

  assign computed = (op[3:2] == 2'b10);

  // Base operand for the computed page.
  always_comb begin
    base = abh_q;
    unique case (op[1:0])
      2'b00:   base = abh_q;
      2'b01:   base = abh_q + {WIDTH{1'b1}};
      2'b10:   base = pch_q;
      default: base = DB;
    endcase
  end

  // Page select; in deferred mode the carry is left out here and added in FIXUP.
  always_comb begin
    page_adh = ZP_PAGE;
    unique case (op[3:2])
      2'b00:   page_adh = ZP_PAGE;
      2'b01:   page_adh = STACK_PAGE;
      2'b10:   page_adh = (DEFER_CARRY != 0) ? base : base + WIDTH'(CI);
      default: page_adh = VEC_PAGE;
    endcase
  end

  // Next state, next ABH, stall and crossing detection; hold parks everything.
  always_comb begin
    state_nxt = state;
    adh_c     = abh_q;
    stall_c   = 1'b0;
    cross_c   = 1'b0;
    if (!hold) begin
      if (DEFER_CARRY == 0) begin
        adh_c   = page_adh;
        cross_c = computed && CI;
      end else if (state == S_FIXUP) begin
        adh_c     = abh_q + ONE;
        state_nxt = S_NORMAL;
        cross_c   = 1'b1;
      end else begin
        adh_c = page_adh;
        if (computed && CI) begin
          stall_c   = 1'b1;
          state_nxt = S_FIXUP;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_NORMAL;
    end else if (!hold) begin
      state <= state_nxt;
    end
  end

  // Address-high register and crossing pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abh_q    <= RESET_PAGE;
      pcross_q <= 1'b0;
    end else if (!hold) begin
      abh_q    <= adh_c;
      pcross_q <= cross_c;
    end
  end

  // Program counter high loads from the registered ABH, optionally incremented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pch_q <= '0;
    end else if (!hold && ld_pc) begin
      pch_q <= abh_q + WIDTH'(inc_pc);
    end
  end

  // Saturating count of crossing pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!hold && pcross_q && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign ADH        = adh_c;
  assign ABH        = abh_q;
  assign PCH        = pch_q;
  assign stall      = stall_c;
  assign page_cross = pcross_q;
  assign pc_count   = cnt_q;

endmodule

// File: tb/tb_abh_ext.sv
// tb/tb_abh_ext.sv - scoreboard bench for abh_ext in immediate and deferred carry modes
module tb_abh_ext;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Immediate-carry instance with a tiny counter for saturation.
  logic       ci0, ld0, inc0, hold0;
  logic [7:0] db0;
  logic [3:0] op0;
  logic [7:0] adh0, abh0, pch0;
  logic       stall0, pcr0;
  logic [1:0] cnt0;

  // Deferred-carry instance.
  logic        ci1, ld1, inc1, hold1;
  logic [7:0]  db1;
  logic [3:0]  op1;
  logic [7:0]  adh1, abh1, pch1;
  logic        stall1, pcr1;
  logic [15:0] cnt1;

  abh_ext #(.WIDTH(8), .DEFER_CARRY(0), .CNT_W(2)) u_dut0 (
    .clk(clk), .rst(rst), .CI(ci0), .DB(db0), .op(op0), .ld_pc(ld0),
    .inc_pc(inc0), .hold(hold0), .ADH(adh0), .ABH(abh0), .PCH(pch0),
    .stall(stall0), .page_cross(pcr0), .pc_count(cnt0)
  );

  abh_ext #(.WIDTH(8), .DEFER_CARRY(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .CI(ci1), .DB(db1), .op(op1), .ld_pc(ld1),
    .inc_pc(inc1), .hold(hold1), .ADH(adh1), .ABH(abh1), .PCH(pch1),
    .stall(stall1), .page_cross(pcr1), .pc_count(cnt1)
  );

  int checks = 0;
  int errors = 0;
  int n0 = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) chk({tag, "_noexp"}, obs, 32'hDEAD_BEEF);
    else chk(tag, obs, exp_q.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle0();
    op0 = 4'b1000; ci0 = 1'b0; db0 = 8'h00; ld0 = 1'b0; inc0 = 1'b0; hold0 = 1'b0;
  endtask

  task automatic idle1();
    op1 = 4'b1000; ci1 = 1'b0; db1 = 8'h00; ld1 = 1'b0; inc1 = 1'b0; hold1 = 1'b0;
  endtask

  task automatic load0(input logic [7:0] v);
    op0 = 4'b1011; db0 = v; ci0 = 1'b0;
    tick();
    idle0();
  endtask

  task automatic load1(input logic [7:0] v);
    op1 = 4'b1011; db1 = v; ci1 = 1'b0;
    tick();
    idle1();
  endtask

  function automatic logic [31:0] sat3(input int n);
    return (n > 3) ? 32'd3 : 32'(n);
  endfunction

  logic [3:0] cp_op[3];
  logic [7:0] cp_exp[3];

  initial begin
    cp_op[0] = 4'b0000; cp_exp[0] = 8'h00;
    cp_op[1] = 4'b0100; cp_exp[1] = 8'h01;
    cp_op[2] = 4'b1100; cp_exp[2] = 8'hFF;

    rst = 1'b1;
    idle0();
    idle1();
    tick();
    tick();
    push(8'hFF); pop_chk("rst_abh0", abh0);
    push(8'h00); pop_chk("rst_pch0", pch0);
    push(0);     pop_chk("rst_cnt0", cnt0);
    rst = 1'b0;

    // Reset asserted while the deferred instance sits in FIXUP.
    load1(8'h12);
    op1 = 4'b1000; ci1 = 1'b1;
    push(1); #1; pop_chk("fx_stall", stall1);
    tick();
    push(8'h13); pop_chk("fx_adh", adh1);
    rst = 1'b1;
    idle1();
    push(8'hFF); push(8'h00); push(0); push(0); push(0); push(8'hFF);
    #1;
    pop_chk("arst_abh", abh1);
    pop_chk("arst_pch", pch1);
    pop_chk("arst_stall", stall1);
    pop_chk("arst_cnt", cnt1);
    pop_chk("arst_pcr", pcr1);
    pop_chk("arst_adh", adh1);
    tick();
    rst = 1'b0;

    // Immediate carry into the computed page.
    load0(8'h12);
    op0 = 4'b1000; ci0 = 1'b1; n0++;
    push(8'h13); push(8'h13); push(1); push(0); push(sat3(n0));
    #1; pop_chk("imm_adh", adh0);
    tick();
    idle0();
    pop_chk("imm_abh", abh0);
    pop_chk("imm_pcr", pcr0);
    tick();
    pop_chk("imm_pcr_end", pcr0);
    pop_chk("imm_cnt", cnt0);

    // Deferred carry: stall, fix-up, then crossing pulse.
    op1 = 4'b1011; db1 = 8'h7F; ci1 = 1'b1;
    push(8'h7F); push(1); push(8'h80); push(0); push(0); push(8'h80); push(1); push(0); push(1);
    #1;
    pop_chk("def_adh0", adh1);
    pop_chk("def_stall0", stall1);
    tick();
    db1 = 8'h00;
    #1;
    pop_chk("def_adh1", adh1);
    pop_chk("def_stall1", stall1);
    pop_chk("def_pcr1", pcr1);
    tick();
    idle1();
    pop_chk("def_abh2", abh1);
    pop_chk("def_pcr2", pcr1);
    tick();
    pop_chk("def_pcr3", pcr1);
    pop_chk("def_cnt", cnt1);

    op1 = 4'b1011; db1 = 8'h7F; ci1 = 1'b0;
    push(0); push(8'h7F); push(8'h7F); push(0);
    #1;
    pop_chk("nc_stall", stall1);
    pop_chk("nc_adh", adh1);
    tick();
    idle1();
    pop_chk("nc_abh", abh1);
    pop_chk("nc_pcr", pcr1);

    // Constant pages ignore the carry.
    load1(8'h34);
    ci1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op1 = cp_op[i];
      push(cp_exp[i]); push(0);
      #1;
      pop_chk("cp_adh", adh1);
      pop_chk("cp_stall", stall1);
    end
    op1 = 4'b0000;
    push(8'h00); push(0);
    tick();
    idle1();
    pop_chk("cp_abh", abh1);
    pop_chk("cp_pcr", pcr1);

    load0(8'h34);
    op0 = 4'b1100; ci0 = 1'b1;
    push(8'hFF); push(8'hFF); push(0);
    #1; pop_chk("cp0_adh", adh0);
    tick();
    idle0();
    pop_chk("cp0_abh", abh0);
    pop_chk("cp0_pcr", pcr0);

    // Hold across a pending fix-up.
    load1(8'h40);
    op1 = 4'b1000; ci1 = 1'b1;
    push(1); #1; pop_chk("hd_stall_in", stall1);
    tick();
    hold1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(8'h40); push(8'h40); push(0); push(0);
      #1;
      pop_chk("hd_abh", abh1);
      pop_chk("hd_adh", adh1);
      pop_chk("hd_stall", stall1);
      pop_chk("hd_pcr", pcr1);
      tick();
    end
    hold1 = 1'b0;
    push(8'h41); push(8'h41); push(1);
    #1; pop_chk("hd_rel_adh", adh1);
    tick();
    idle1();
    pop_chk("hd_rel_abh", abh1);
    pop_chk("hd_rel_pcr", pcr1);

    // PCH loading, hold and inc-without-load.
    load0(8'hFF);
    ld0 = 1'b1; inc0 = 1'b1;
    push(8'h00);
    tick();
    idle0();
    pop_chk("pch_wrap", pch0);
    load0(8'h20);
    hold0 = 1'b1; ld0 = 1'b1;
    push(8'h00); push(8'h20);
    tick();
    idle0();
    pop_chk("pch_hold", pch0);
    pop_chk("pch_hold_abh", abh0);
    ld0 = 1'b1;
    push(8'h20);
    tick();
    idle0();
    pop_chk("pch_load", pch0);
    inc0 = 1'b1;
    push(8'h20);
    tick();
    idle0();
    pop_chk("pch_inc_only", pch0);
    push(sat3(n0)); pop_chk("cnt_mid", cnt0);

    // Base from PCH, from ABH-1 with carry, and FF wrap.
    op0 = 4'b1010; ci0 = 1'b1; n0++;
    push(8'h21); push(8'h21); push(1);
    #1; pop_chk("pcb_adh", adh0);
    tick();
    idle0();
    pop_chk("pcb_abh", abh0);
    pop_chk("pcb_pcr", pcr0);

    op0 = 4'b1001; ci0 = 1'b1; n0++;
    push(8'h21); push(8'h21); push(1);
    #1; pop_chk("dec_adh", adh0);
    tick();
    idle0();
    pop_chk("dec_abh", abh0);
    pop_chk("dec_pcr", pcr0);

    load0(8'hFF);
    op0 = 4'b1000; ci0 = 1'b1; n0++;
    push(8'h00); push(8'h00); push(1);
    #1; pop_chk("ff_adh", adh0);
    tick();
    idle0();
    pop_chk("ff_abh", abh0);
    pop_chk("ff_pcr", pcr0);

    // Saturation of the 2-bit counter.
    for (int i = 0; i < 4; i++) begin
      op0 = 4'b1000; ci0 = 1'b1; n0++;
      tick();
    end
    idle0();
    tick();
    tick();
    push(sat3(n0)); pop_chk("cnt_sat", cnt0);
    push(0); pop_chk("cnt_sat_pcr", pcr0);

    if (exp_q.size() != 0) chk("sb_leftover", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
